// File: rtl/emb_seq_ctrl_if.sv
// Upstream/downstream level handshake of the embedding sequencer: line request
// in (run/d), embedding matrix out (valid/q).
interface emb_seq_ctrl_if #(
    parameter int unsigned CHAR_NUM = 10,
    parameter int unsigned CHAR_LEN = 8,
    parameter int unsigned EMB_DIM  = 24,
    parameter int unsigned N_LEN    = 16
);
    localparam int unsigned LINE_W = CHAR_NUM * CHAR_LEN;
    localparam int unsigned MAT_W  = CHAR_NUM * EMB_DIM * N_LEN;

    logic              run;
    logic [LINE_W-1:0] d;
    logic              valid;
    logic [MAT_W-1:0]  q;

    modport master (output run, d, input  valid, q);
    modport slave  (input  run, d, output valid, q);
endinterface

// File: rtl/emb_seq_ctrl.sv
// Feeds a latched line of character codes to emb_block one at a time and assembles
// the embedding matrix. Optional pad skipping is enabled by EMB_SEQ_PAD_SKIP_EN.
`ifndef CHAR_LEN
`define CHAR_LEN 8
`endif
`ifndef EMB_DIM
`define EMB_DIM 24
`endif
`ifndef N_LEN
`define N_LEN 16
`endif

module emb_seq_ctrl #(
    parameter int unsigned CHAR_NUM = 10,
    parameter int unsigned CHAR_LEN = `CHAR_LEN,
    parameter int unsigned EMB_DIM  = `EMB_DIM,
    parameter int unsigned N_LEN    = `N_LEN
`ifdef EMB_SEQ_PAD_SKIP_EN
  , parameter logic [CHAR_LEN-1:0] PAD_CHAR = '0
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    emb_seq_ctrl_if.slave              up,
    output logic                       emb_run,
    output logic [CHAR_LEN-1:0]        emb_d,
    input  logic                       emb_valid,
    input  logic [EMB_DIM*N_LEN-1:0]   emb_q
);
    localparam int unsigned IDX_W  = (CHAR_NUM > 1) ? $clog2(CHAR_NUM) : 1;
    localparam int unsigned SLOT_W = EMB_DIM * N_LEN;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAR_NUM - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                            state;
    logic [IDX_W-1:0]                  idx;
    logic                              valid_r;
    logic [CHAR_NUM-1:0][CHAR_LEN-1:0] line;
    logic [CHAR_NUM-1:0][SLOT_W-1:0]   slots;

    // Char 0 sits in the low-order bits of both the line and the matrix.
    assign emb_d    = line[idx];
    assign up.valid = valid_r;
    assign up.q     = slots;

    // Sequencer: one LOAD cycle per char lets emb_block reload its address before run rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            emb_run <= 1'b0;
            valid_r <= 1'b0;
            line    <= '0;
            slots   <= '0;
        end else if (!up.run) begin
            state   <= IDLE;
            idx     <= '0;
            emb_run <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    line  <= up.d;
                    idx   <= '0;
                    state <= LOAD;
                end
                LOAD: begin
`ifdef EMB_SEQ_PAD_SKIP_EN
                    if (line[idx] == PAD_CHAR) begin
                        slots[idx] <= '0;
                        if (idx == LAST_IDX) begin
                            state   <= DONE;
                            valid_r <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        state   <= RUN;
                        emb_run <= 1'b1;
                    end
`else
                    state   <= RUN;
                    emb_run <= 1'b1;
`endif
                end
                RUN: begin
                    if (emb_valid) begin
                        slots[idx] <= emb_q;
                        emb_run    <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state   <= DONE;
                            valid_r <= 1'b1;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
